// File: rtl/m65c02_wrsel_pkg.sv
// -----------------------------------------------------------------------------
// m65c02_wrsel_pkg
//
// Shared definitions for the M65C02A register write-select unit.
//   - Lane indices of the architectural registers in the write-enable vector.
//   - Encodings of the microprogram Reg_WE field. The instruction-decoder
//     WSel field uses the same code points, so one enum serves both.
//   - we_lanes(): maps a "direct" code (anything but WE_WSEL) onto the five
//     architectural lanes {S,P,Y,X,A}.
// -----------------------------------------------------------------------------
package m65c02_wrsel_pkg;

    // Lane indices inside the write-enable vector
    localparam int REG_A = 0;
    localparam int REG_X = 1;
    localparam int REG_Y = 2;
    localparam int REG_P = 3;
    localparam int REG_S = 4;

    // Number of architectural lanes; anything above is reserved
    localparam int NARCH = 5;

    // Reg_WE / WSel code points
    typedef enum logic [2:0] {
        WE_NONE = 3'b000,
        WE_A    = 3'b001,
        WE_X    = 3'b010,
        WE_Y    = 3'b011,
        WE_WSEL = 3'b100,
        WE_S    = 3'b101,
        WE_P    = 3'b110,
        WE_RSVD = 3'b111
    } wr_code_e;

    // Lane set written by a direct code. A/X/Y loads also update the flags,
    // hence the P lane alongside. WE_WSEL and WE_RSVD write nothing here;
    // the caller resolves WE_WSEL before calling.
    function automatic logic [NARCH-1:0] we_lanes(input logic [2:0] code);
        logic [NARCH-1:0] v;
        v = '0;
        case (code)
            WE_A: begin
                v[REG_A] = 1'b1;
                v[REG_P] = 1'b1;
            end
            WE_X: begin
                v[REG_X] = 1'b1;
                v[REG_P] = 1'b1;
            end
            WE_Y: begin
                v[REG_Y] = 1'b1;
                v[REG_P] = 1'b1;
            end
            WE_S:    v[REG_S] = 1'b1;
            WE_P:    v[REG_P] = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage : m65c02_wrsel_pkg

// File: rtl/m65c02_wrsel_dec.sv
// -----------------------------------------------------------------------------
// m65c02_wrsel_dec
//
// Purely combinational decode of the write-select fields into a write-enable
// vector over NREGS lanes. Lanes 5..NREGS-1 are reserved and driven to 0.
//
// Optional build macro: WRSEL_OSX_EN
//   When defined, an active OSX prefix redirects an X write to S (the flags
//   lane is untouched, so X+P becomes S+P). When undefined OSX is ignored.
//
// Ports:
//   Reg_WE  in   3      microprogram write-enable field
//   WSel    in   3      instruction-decoder select, used when Reg_WE = WE_WSEL
//   Valid   in   1      fields are meaningful; D is 0 otherwise
//   OSX     in   1      operand-size / stack-override prefix
//   D       out  NREGS  decoded write-enable vector
// -----------------------------------------------------------------------------
module m65c02_wrsel_dec
    import m65c02_wrsel_pkg::*;
#(
    parameter int NREGS = 8
) (
    input  logic [2:0]       Reg_WE,
    input  logic [2:0]       WSel,
    input  logic             Valid,
    input  logic             OSX,
    output logic [NREGS-1:0] D
);

    logic [2:0]       code;
    logic [NARCH-1:0] lanes;

    // Resolve the indirect WSel code into a direct code. WSel differs from
    // Reg_WE in two points: 100 writes nothing and 111 writes P.
    always_comb begin
        code = Reg_WE;
        if (Reg_WE == WE_WSEL) begin
            if (WSel == WE_RSVD) begin
                code = WE_P;
            end else if (WSel == WE_WSEL) begin
                code = WE_NONE;
            end else begin
                code = WSel;
            end
        end
    end

`ifdef WRSEL_OSX_EN
    always_comb begin
        lanes = we_lanes(code);
        if (OSX && lanes[REG_X]) begin
            lanes[REG_X] = 1'b0;
            lanes[REG_S] = 1'b1;
        end
    end
`else
    logic osx_unused;
    assign osx_unused = OSX;

    always_comb begin
        lanes = we_lanes(code);
    end
`endif

    // Reserved lanes stay 0; nothing is written unless Valid.
    always_comb begin
        D = '0;
        if (Valid) begin
            D[NARCH-1:0] = lanes;
        end
    end

endmodule : m65c02_wrsel_dec

// File: rtl/m65c02_wrsel_pipe.sv
// -----------------------------------------------------------------------------
// m65c02_wrsel_pipe
//
// Register write-select unit for the M65C02A core. The decoded write-enable
// vector is carried through a DEPTH-stage pipeline; the last stage drives the
// writeback select. A pending-write scoreboard (OR of all stages) flags a
// read-after-write hazard for the instruction in decode.
//
// Optional build macro: WRSEL_OSX_EN (OSX redirects X writes to S, see the
// decoder). The default build ignores OSX.
//
// Parameters:
//   NREGS  write-enable lanes (>= 5); A=0 X=1 Y=2 P=3 S=4, rest reserved
//   DEPTH  stages from decode to writeback select (>= 1)
//
// Ports:
//   Clk      in   1      clock, rising edge
//   nRst     in   1      asynchronous active-low reset
//   Rdy      in   1      pipeline advance enable
//   Valid    in   1      Reg_WE/WSel meaningful this cycle
//   Flush    in   1      discard in-flight writes not yet at writeback
//   Reg_WE   in   3      microprogram write-enable field
//   WSel     in   3      instruction-decoder write select
//   OSX      in   1      operand-size / stack-override prefix
//   Rd_Sel   in   NREGS  registers read by the instruction in decode
//   Sel      out  NREGS  writeback-stage write enables
//   Sel_Vld  out  1      Sel has at least one bit set
//   Pend     out  NREGS  OR of all pipeline stages
//   Stall    out  1      a read in decode hits a write not yet at writeback
//
// Handshake: there is no backpressure from this block. Stall is advisory;
// the sequencer must drop Rdy/Valid itself. A stage word moves only on an
// edge with Rdy = 1, and Flush acts on its edge regardless of Rdy.
// -----------------------------------------------------------------------------
module m65c02_wrsel_pipe
    import m65c02_wrsel_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int DEPTH = 2
) (
    input  logic             Clk,
    input  logic             nRst,
    input  logic             Rdy,
    input  logic             Valid,
    input  logic             Flush,
    input  logic [2:0]       Reg_WE,
    input  logic [2:0]       WSel,
    input  logic             OSX,
    input  logic [NREGS-1:0] Rd_Sel,
    output logic [NREGS-1:0] Sel,
    output logic             Sel_Vld,
    output logic [NREGS-1:0] Pend,
    output logic             Stall
);

    logic [NREGS-1:0]            dec_vec;
    logic [DEPTH-1:0][NREGS-1:0] stg_q;
    logic [DEPTH-1:0][NREGS-1:0] stg_d;
    logic [NREGS-1:0]            pend_hz;

    m65c02_wrsel_dec #(
        .NREGS (NREGS)
    ) u_dec (
        .Reg_WE (Reg_WE),
        .WSel   (WSel),
        .Valid  (Valid),
        .OSX    (OSX),
        .D      (dec_vec)
    );

    // Next-state of the pipeline.
    // Flush with Rdy: stages 0..DEPTH-2 clear, and the writeback stage takes
    // the (cleared) word from the stage before it, so the whole pipe empties.
    // Flush without Rdy: the writeback stage holds, the rest clear.
    // The decode word presented with Flush is always dropped.
    always_comb begin
        stg_d = stg_q;
        if (Rdy) begin
            stg_d[0] = Flush ? '0 : dec_vec;
            for (int i = 1; i < DEPTH; i++) begin
                stg_d[i] = Flush ? '0 : stg_q[i-1];
            end
        end else if (Flush) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                stg_d[i] = '0;
            end
        end
    end

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            stg_q <= '0;
        end else begin
            stg_q <= stg_d;
        end
    end

    // Scoreboard. The writeback stage is excluded from the hazard set: its
    // write lands this cycle, so a read in decode sees the new value.
    always_comb begin
        Pend    = '0;
        pend_hz = '0;
        for (int i = 0; i < DEPTH; i++) begin
            Pend = Pend | stg_q[i];
            if (i < DEPTH - 1) begin
                pend_hz = pend_hz | stg_q[i];
            end
        end
    end

    assign Sel     = stg_q[DEPTH-1];
    assign Sel_Vld = |stg_q[DEPTH-1];
    assign Stall   = |(Rd_Sel & pend_hz);

endmodule : m65c02_wrsel_pipe

// File: tb/tb_m65c02_wrsel_pipe.sv
// -----------------------------------------------------------------------------
// tb_m65c02_wrsel_pipe
//
// Directed bench for m65c02_wrsel_pipe at NREGS = 8, DEPTH = 2. Inputs change
// 1 time unit after a rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_m65c02_wrsel_pipe;

    localparam int NREGS = 8;
    localparam int DEPTH = 2;

    // Lane patterns: A=01 X=02 Y=04 P=08 S=10
    localparam logic [7:0] V_NONE = 8'h00;
    localparam logic [7:0] V_AP   = 8'h09;
    localparam logic [7:0] V_XP   = 8'h0A;
    localparam logic [7:0] V_YP   = 8'h0C;
    localparam logic [7:0] V_S    = 8'h10;
    localparam logic [7:0] V_P    = 8'h08;
`ifdef WRSEL_OSX_EN
    localparam logic [7:0] V_OSX  = 8'h18;
`else
    localparam logic [7:0] V_OSX  = 8'h0A;
`endif

    logic             Clk = 1'b0;
    logic             nRst = 1'b0;
    logic             Rdy = 1'b1;
    logic             Valid = 1'b0;
    logic             Flush = 1'b0;
    logic [2:0]       Reg_WE = 3'b000;
    logic [2:0]       WSel = 3'b000;
    logic             OSX = 1'b0;
    logic [NREGS-1:0] Rd_Sel = '0;
    logic [NREGS-1:0] Sel;
    logic             Sel_Vld;
    logic [NREGS-1:0] Pend;
    logic             Stall;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 Clk = ~Clk;

    m65c02_wrsel_pipe #(
        .NREGS (NREGS),
        .DEPTH (DEPTH)
    ) dut (
        .Clk     (Clk),
        .nRst    (nRst),
        .Rdy     (Rdy),
        .Valid   (Valid),
        .Flush   (Flush),
        .Reg_WE  (Reg_WE),
        .WSel    (WSel),
        .OSX     (OSX),
        .Rd_Sel  (Rd_Sel),
        .Sel     (Sel),
        .Sel_Vld (Sel_Vld),
        .Pend    (Pend),
        .Stall   (Stall)
    );

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] we, input logic [2:0] ws);
        Valid  = v;
        Reg_WE = we;
        WSel   = ws;
    endtask

    // Two idle Rdy edges empty a DEPTH=2 pipe.
    task automatic idle();
        drive(1'b0, 3'b000, 3'b000);
        Rdy   = 1'b1;
        Flush = 1'b0;
        OSX   = 1'b0;
        Rd_Sel = '0;
        step();
        step();
    endtask

    // Feed a sequence back-to-back; Sel lags capture by DEPTH edges.
    task automatic sweep(input logic [2:0] we_v[8], input logic [2:0] ws_v[8],
                         input logic [7:0] ex_v[8], input string tag);
        logic [7:0] e;
        exp_q.delete();
        exp_q.push_back(V_NONE);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, we_v[i], ws_v[i]);
            step();
            e = exp_q.pop_front();
            check_eq($sformatf("%s_sel%0d", tag, i), Sel, e);
            check_eq($sformatf("%s_vld%0d", tag, i), {7'd0, Sel_Vld}, {7'd0, |e});
            exp_q.push_back(ex_v[i]);
        end
        drive(1'b0, 3'b000, 3'b000);
        step();
        e = exp_q.pop_front();
        check_eq({tag, "_sel_last"}, Sel, e);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] we_v[8];
        logic [2:0] ws_v[8];
        logic [7:0] ex_v[8];

        // Reset state
        Rd_Sel = 8'hFF;
        #2;
        check_eq("rst_sel", Sel, V_NONE);
        check_eq("rst_pend", Pend, V_NONE);
        check_eq("rst_stall", {7'd0, Stall}, 8'h00);
        #10 nRst = 1'b1;
        Rd_Sel = '0;
        step();

        // Reset mid-stream
        drive(1'b1, 3'b001, 3'b000);
        step();
        step();
        check_eq("pre_rst_sel", Sel, V_AP);
        check_eq("pre_rst_pend", Pend, V_AP);
        drive(1'b0, 3'b000, 3'b000);
        Rd_Sel = 8'hFF;
        #1;
        check_eq("pre_rst_stall", {7'd0, Stall}, 8'h01);
        #1 nRst = 1'b0;
        #1;
        check_eq("mid_rst_sel", Sel, V_NONE);
        check_eq("mid_rst_pend", Pend, V_NONE);
        check_eq("mid_rst_stall", {7'd0, Stall}, 8'h00);
        check_eq("mid_rst_vld", {7'd0, Sel_Vld}, 8'h00);
        #1 nRst = 1'b1;
        Rd_Sel = '0;
        drive(1'b1, 3'b010, 3'b000);
        step();
        check_eq("post_rst_sel0", Sel, V_NONE);
        drive(1'b0, 3'b000, 3'b000);
        step();
        check_eq("post_rst_sel1", Sel, V_XP);
        idle();

        // Reg_WE decode sweep
        we_v = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        ws_v = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        ex_v = '{V_NONE, V_AP, V_XP, V_YP, V_NONE, V_S, V_P, V_NONE};
        sweep(we_v, ws_v, ex_v, "we");

        // WSel decode sweep under Reg_WE = 100
        we_v = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
        ws_v = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        ex_v = '{V_NONE, V_AP, V_XP, V_YP, V_NONE, V_S, V_P, V_P};
        sweep(we_v, ws_v, ex_v, "wsel");
        idle();

        // Valid = 0 suppresses decode
        drive(1'b0, 3'b001, 3'b000);
        step();
        check_eq("novalid_pend", Pend, V_NONE);
        step();
        check_eq("novalid_sel", Sel, V_NONE);
        idle();

        // Hazard / stall
        drive(1'b1, 3'b001, 3'b000);
        step();
        drive(1'b0, 3'b000, 3'b000);
        Rd_Sel = 8'h10;
        #1;
        check_eq("hz_miss_stall", {7'd0, Stall}, 8'h00);
        Rd_Sel = 8'h01;
        #1;
        check_eq("hz_hit_stall", {7'd0, Stall}, 8'h01);
        check_eq("hz_pend", Pend, V_AP);
        check_eq("hz_sel0", Sel, V_NONE);
        step();
        check_eq("hz_wb_stall", {7'd0, Stall}, 8'h00);
        check_eq("hz_wb_sel", Sel, V_AP);
        check_eq("hz_wb_pend", Pend, V_AP);
        idle();

        // Rdy hold
        drive(1'b1, 3'b011, 3'b000);
        step();
        drive(1'b0, 3'b000, 3'b000);
        Rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("hold_sel%0d", i), Sel, V_NONE);
            check_eq($sformatf("hold_pend%0d", i), Pend, V_YP);
        end
        Rdy = 1'b1;
        step();
        check_eq("hold_rel_sel", Sel, V_YP);
        idle();

        // Flush with Rdy: stg0 = A+P, stg1 = S
        drive(1'b1, 3'b101, 3'b000);
        step();
        drive(1'b1, 3'b001, 3'b000);
        step();
        check_eq("fl_pre_sel", Sel, V_S);
        check_eq("fl_pre_pend", Pend, 8'h19);
        drive(1'b1, 3'b110, 3'b000);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        drive(1'b0, 3'b000, 3'b000);
        check_eq("fl_sel", Sel, V_NONE);
        check_eq("fl_pend", Pend, V_NONE);
        step();
        check_eq("fl_drop_sel", Sel, V_NONE);
        idle();

        // Flush without Rdy: writeback stage holds, stg0 clears
        drive(1'b1, 3'b010, 3'b000);
        step();
        drive(1'b1, 3'b001, 3'b000);
        step();
        drive(1'b1, 3'b110, 3'b000);
        Flush = 1'b1;
        Rdy = 1'b0;
        step();
        Flush = 1'b0;
        Rdy = 1'b1;
        drive(1'b0, 3'b000, 3'b000);
        check_eq("flnr_sel", Sel, V_XP);
        check_eq("flnr_pend", Pend, V_XP);
        step();
        check_eq("flnr_next_sel", Sel, V_NONE);
        idle();

        // OSX prefix on an X write, direct and via WSel
        drive(1'b1, 3'b010, 3'b000);
        OSX = 1'b1;
        step();
        drive(1'b1, 3'b100, 3'b010);
        step();
        drive(1'b0, 3'b000, 3'b000);
        OSX = 1'b0;
        check_eq("osx_we_sel", Sel, V_OSX);
        step();
        check_eq("osx_wsel_sel", Sel, V_OSX);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_m65c02_wrsel_pipe
